// File: rtl/roi_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// roi_scan_ctrl_if
//   Bundles the scan-harness signals that sit between a test driver, the
//   roi_scan_ctrl block and the ROI it wraps.
//
//   Signals
//     start     driver -> ctrl   begin a scan transaction
//     di        driver -> ctrl   serial scan-in bit
//     dout      ROI    -> ctrl   parallel ROI result vector (DOUT_N)
//     din       ctrl   -> ROI    registered parallel ROI input vector (DIN_N)
//     do_bit    ctrl   -> pin    serial scan-out bit ("do" is a reserved word)
//     do_valid  ctrl   -> pin    do_bit carries a valid result bit
//     busy      ctrl   -> driver transaction in progress
//     done      ctrl   -> driver one-cycle completion pulse
//     crc       ctrl   -> driver CRC-8 of the scanned-out bits
//
//   Modports
//     master : the driving side (test harness / ROI model)
//     slave  : roi_scan_ctrl
// ---------------------------------------------------------------------------
interface roi_scan_ctrl_if #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256
);
  logic              start;
  logic              di;
  logic [DIN_N-1:0]  din;
  logic [DOUT_N-1:0] dout;
  logic              do_bit;
  logic              do_valid;
  logic              busy;
  logic              done;
  logic [7:0]        crc;

  modport master (
    output start, di, dout,
    input  din, do_bit, do_valid, busy, done, crc
  );

  modport slave (
    input  start, di, dout,
    output din, do_bit, do_valid, busy, done, crc
  );
endinterface

// File: rtl/roi_scan_ctrl.sv
// ---------------------------------------------------------------------------
// roi_scan_ctrl
//   One-pin-in / one-pin-out scan harness around a minitest ROI. A transaction
//   shifts DIN_N bits in from di, applies them in parallel on din, waits
//   SETTLE_CYC cycles, captures the ROI result dout and shifts DOUT_N bits out
//   MSB first on do_bit while do_valid is high, then pulses done.
//
//   Ports
//     clk    in   single clock, rising edge
//     rst_n  in   asynchronous active-low reset; aborts any transaction
//     bus    roi_scan_ctrl_if.slave (start, di, dout in; din, do_bit,
//            do_valid, busy, done, crc out)
//
//   Build option
//     ROI_SCAN_CRC_EN : when defined, crc is a CRC-8 (poly 0x07, init 0x00,
//                       MSB first) over the scanned-out bits. When undefined
//                       crc is tied to zero and no CRC logic exists.
// ---------------------------------------------------------------------------
module roi_scan_ctrl #(
  parameter int DIN_N      = 256,
  parameter int DOUT_N     = 256,
  parameter int SETTLE_CYC = 2
) (
  input logic             clk,
  input logic             rst_n,
  roi_scan_ctrl_if.slave  bus
);

  localparam int MAX_IO = (DIN_N > DOUT_N) ? DIN_N : DOUT_N;
  localparam int MAX_N  = (MAX_IO > SETTLE_CYC) ? MAX_IO : SETTLE_CYC;
  localparam int CNT_W  = $clog2(MAX_N) + 1;

  localparam logic [CNT_W-1:0] DIN_LAST    = CNT_W'(DIN_N - 1);
  localparam logic [CNT_W-1:0] DOUT_LAST   = CNT_W'(DOUT_N - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIN_N-1:0]   din_shr_q, din_shr_d;
  logic [DIN_N-1:0]   din_q, din_d;
  logic [DOUT_N-1:0]  dout_shr_q, dout_shr_d;
  logic               busy, done, do_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; each counted state exits on its terminal count
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.start) state_d = S_SHIFT_IN;
      S_SHIFT_IN:  if (cnt_q == DIN_LAST) state_d = S_APPLY;
      S_APPLY:     state_d = S_SETTLE;
      S_SETTLE:    if (cnt_q == SETTLE_LAST) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_SHIFT_OUT;
      S_SHIFT_OUT: if (cnt_q == DOUT_LAST) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    do_valid = (state_q == S_SHIFT_OUT);
  end

  // Datapath next values. The counter is cleared on the terminal count so it
  // always starts each counted state from zero.
  always_comb begin
    cnt_d      = '0;
    din_shr_d  = din_shr_q;
    din_d      = din_q;
    dout_shr_d = dout_shr_q;
    case (state_q)
      S_SHIFT_IN: begin
        din_shr_d = {din_shr_q[DIN_N-2:0], bus.di};
        cnt_d     = (cnt_q == DIN_LAST) ? '0 : cnt_q + CNT_ONE;
      end
      S_APPLY: begin
        din_d = din_shr_q;
      end
      S_SETTLE: begin
        cnt_d = (cnt_q == SETTLE_LAST) ? '0 : cnt_q + CNT_ONE;
      end
      S_CAPTURE: begin
        dout_shr_d = bus.dout;
      end
      S_SHIFT_OUT: begin
        dout_shr_d = {dout_shr_q[DOUT_N-2:0], 1'b0};
        cnt_d      = (cnt_q == DOUT_LAST) ? '0 : cnt_q + CNT_ONE;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      din_shr_q  <= '0;
      din_q      <= '0;
      dout_shr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      din_shr_q  <= din_shr_d;
      din_q      <= din_d;
      dout_shr_q <= dout_shr_d;
    end
  end

`ifdef ROI_SCAN_CRC_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // CRC cleared on an accepted start, folded with each bit shown on do_bit,
  // and held from DONE until the next start.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && bus.start) begin
      crc_d = '0;
    end else if (state_q == S_SHIFT_OUT) begin
      crc_d = crc8_step(crc_q, dout_shr_q[DOUT_N-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign bus.crc = crc_q;
`else
  assign bus.crc = 8'h00;
`endif

  assign bus.din      = din_q;
  assign bus.do_bit   = dout_shr_q[DOUT_N-1];
  assign bus.do_valid = do_valid;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule
